imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the single port of the instruction memory. It arbitrates between a boot loader that writes program words and the IF stage that reads them. In run mode it sequences the PC and hides the 1-cycle memory read latency with a 2-entry instruction queue. It hands instructions to the IF/ID register over a valid/ready handshake and services branch/jump redirects with a flush.

---
 rtl/imem_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller owning the single instruction-memory port.
// BOOT mode lets a loader write program words; RUN mode streams reads through
// a 2-entry queue toward the IF/ID register and services redirect flushes.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_en,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_ins,
    input  logic              if_ready,
    output logic              fetch_err
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        inflight_q, inflight_d;   // non-stale read whose data returns this cycle
    logic [31:0] rd_pc_q, rd_pc_d;         // PC of the read in flight
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] q_pc_q  [2];
    logic [31:0] q_ins_q [2];

    logic        pop;
    logic        push;
    logic        flush;
    logic        issue;
    logic [2:0]  occ;
    logic        wr_idx;

    // Queue head drives the IF/ID handshake directly.
    assign if_valid = (count_q != 2'd0);
    assign if_pc    = q_pc_q[head_q];
    assign if_ins   = q_ins_q[head_q];

    // Handshake, flush and read-issue decisions for the current cycle.
    always_comb begin
        pop    = if_valid && if_ready;
        // A redirect or a return to BOOT discards everything queued or in flight.
        flush  = (state_q == ST_RUN) && (redirect_valid || boot_en);
        // Slots already committed after this cycle's pop; a new read needs one free.
        occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue  = (state_q == ST_RUN) && !flush && (occ < 3'd2);
        push   = (state_q == ST_RUN) && !flush && inflight_q;
        wr_idx = head_q ^ count_q[0];
    end

    // Next-state logic: mode FSM, fetch PC sequencing and queue bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_pc_d    = rd_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        head_d     = head_q;

        case (state_q)
            ST_BOOT: begin
                if (!boot_en) begin
                    state_d    = ST_RUN;
                    fetch_pc_d = RESET_PC;
                end
            end
            ST_RUN: begin
                if (boot_en) begin
                    state_d = ST_BOOT;
                end
                // Redirect target is taken even when BOOT wins the same cycle.
                if (redirect_valid) begin
                    fetch_pc_d = {redirect_pc[31:2], 2'b00};
                end else if (issue) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (issue) begin
            rd_pc_d = fetch_pc_q;
        end

        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            head_d  = head_q ^ pop;
        end
    end

    // Memory port, loader handshake and misalignment pulse.
    always_comb begin
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fetch_err = 1'b0;

        // rst_n gating keeps the loader outputs quiet while reset is held.
        if ((state_q == ST_BOOT) && rst_n) begin
            ld_ready = boot_en;
            if (boot_en && ld_valid) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
            end
        end else if (issue) begin
            mem_en   = 1'b1;
            mem_addr = fetch_pc_q[ADDR_W+1:2];
        end

        if ((state_q == ST_RUN) && redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_err = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // Queue storage: a returning read is written into the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage is reset because the head entry drives if_pc/if_ins,
            // which must read zero out of reset.
            for (int i = 0; i < 2; i++) begin
                q_pc_q[i]  <= '0;
                q_ins_q[i] <= '0;
            end
        end else if (push) begin
            q_pc_q[wr_idx]  <= rd_pc_q;
            q_ins_q[wr_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a behavioural 1-cycle-latency
// memory, a scoreboard of expected {pc, ins} pairs consumed on every IF/ID
// transfer, and per-scenario tasks with cycle-exact checks.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam int ADDR_W = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } item_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              boot_en;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_ins;
    logic              if_ready;
    logic              fetch_err;

    logic [31:0] tmem [256];
    logic [31:0] prog [256];
    item_t       exp_q [$];
    item_t       sb_e;
    int          total   = 0;
    int          bad     = 0;
    int          sb_pops = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_en        (boot_en),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_ins         (if_ins),
        .if_ready       (if_ready),
        .fetch_err      (fetch_err)
    );

    // Single-port instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= tmem[mem_addr];
        end
    end

    // Scoreboard sink: every accepted head must match the next expected entry.
    // Redirect and boot_en flush the head, so no transfer happens then.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready && !redirect_valid && !boot_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_pop: got pc=%h ins=%h, expected no transfer", if_pc, if_ins);
            end else begin
                sb_e = exp_q.pop_front();
                if ({if_pc, if_ins} !== sb_e) begin
                    bad++;
                    $display("FAIL sb_pop: got pc=%h ins=%h, want pc=%h ins=%h",
                             if_pc, if_ins, sb_e.pc, sb_e.ins);
                end
                sb_pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return prog[pc[9:2]];
    endfunction

    task automatic expect_stream(input logic [31:0] start, input int n);
        item_t it;
        for (int i = 0; i < n; i++) begin
            it.pc  = start + 32'(i * 4);
            it.ins = word_at(it.pc);
            exp_q.push_back(it);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; boot_en = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ld_ready, mem_en, mem_we, mem_addr, mem_wdata, if_valid, if_pc, if_ins, fetch_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ld_ready=%b mem_en=%b if_valid=%b if_pc=%h fetch_err=%b, want all 0",
                     ld_ready, mem_en, if_valid, if_pc, fetch_err);
        end
        tick(); rst_n = 1'b1; boot_en = 1'b1;
        @(negedge clk);
        total++;
        if ({ld_ready, mem_en, if_valid} !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: got ld_ready=%b mem_en=%b if_valid=%b, want 1 0 0",
                     ld_ready, mem_en, if_valid);
        end
    endtask

    task automatic test_boot_load();
        for (int i = 0; i < 32; i++) begin
            tick(); ld_valid = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
            @(negedge clk);
            total++;
            if ({ld_ready, mem_en, mem_we, mem_addr, mem_wdata, if_valid} !==
                {1'b1, 1'b1, 1'b1, 8'(i), prog[i], 1'b0}) begin
                bad++;
                $display("FAIL boot_write[%0d]: got rdy=%b en=%b we=%b addr=%h wdata=%h, want 1 1 1 %h %h",
                         i, ld_ready, mem_en, mem_we, mem_addr, mem_wdata, 8'(i), prog[i]);
            end
        end
        // Idle loader plus a misaligned redirect: nothing must happen in BOOT.
        tick(); ld_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        total++;
        if ({mem_en, fetch_err, if_valid, ld_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL boot_idle: got en=%b err=%b valid=%b rdy=%b, want 0 0 0 1",
                     mem_en, fetch_err, if_valid, ld_ready);
        end
    endtask

    task automatic test_stream();
        tick(); redirect_valid = 1'b0; boot_en = 1'b0; if_ready = 1'b1;
        exp_q.delete(); expect_stream(32'h0, 16);
        @(negedge clk);
        total++;
        if ({mem_en, ld_ready, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL boot_exit: got en=%b rdy=%b valid=%b, want 0 0 0", mem_en, ld_ready, if_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            total++;
            if ({mem_en, mem_we, mem_addr, if_valid} !== {2'b10, 8'(k), 1'(k >= 2)}) begin
                bad++;
                $display("FAIL stream[%0d]: got en=%b we=%b addr=%h valid=%b, want 1 0 %h %b",
                         k, mem_en, mem_we, mem_addr, if_valid, 8'(k), k >= 2);
            end
            if (k == 2) begin
                total++;
                if ({if_pc, if_ins} !== {32'h0, 32'h0050_0093}) begin
                    bad++;
                    $display("FAIL stream_first: got pc=%h ins=%h, want 0 00500093", if_pc, if_ins);
                end
            end
            if (k == 3) begin
                total++;
                if ({if_pc, if_ins} !== {32'h4, 32'h0010_0113}) begin
                    bad++;
                    $display("FAIL stream_second: got pc=%h ins=%h, want 4 00100113", if_pc, if_ins);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        int pops0;
        for (int k = 0; k < 5; k++) begin
            tick(); if_ready = 1'b0;
            @(negedge clk);
            total++;
            if ({mem_en, if_valid, if_pc, if_ins} !== {1'b0, 1'b1, 32'h8, prog[2]}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got en=%b valid=%b pc=%h ins=%h, want 0 1 8 %h",
                         k, mem_en, if_valid, if_pc, if_ins, prog[2]);
            end
        end
        pops0 = sb_pops;
        for (int k = 0; k < 4; k++) begin
            tick(); if_ready = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                total++;
                if ({mem_en, mem_we, mem_addr} !== {2'b10, 8'h04}) begin
                    bad++;
                    $display("FAIL bp_resume: got en=%b we=%b addr=%h, want 1 0 04", mem_en, mem_we, mem_addr);
                end
            end
        end
        #1;
        total++;
        if (sb_pops - pops0 !== 4) begin
            bad++;
            $display("FAIL bp_release_count: got %0d transfers, want 4", sb_pops - pops0);
        end
    endtask

    task automatic test_redirect();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        exp_q.delete(); expect_stream(32'h40, 16);
        @(negedge clk);
        total++;
        if ({mem_en, fetch_err} !== 2'b00) begin
            bad++;
            $display("FAIL redir_cycle: got en=%b err=%b, want 0 0", mem_en, fetch_err);
        end
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_en, mem_we, mem_addr, if_valid} !== {2'b10, 8'h10, 1'b0}) begin
            bad++;
            $display("FAIL redir_issue: got en=%b we=%b addr=%h valid=%b, want 1 0 10 0",
                     mem_en, mem_we, mem_addr, if_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if ({mem_addr, if_valid} !== {8'h11, 1'b0}) begin
            bad++;
            $display("FAIL redir_wait: got addr=%h valid=%b, want 11 0", mem_addr, if_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if ({if_valid, if_pc, if_ins} !== {1'b1, 32'h40, prog[16]}) begin
            bad++;
            $display("FAIL redir_first: got valid=%b pc=%h ins=%h, want 1 40 %h", if_valid, if_pc, if_ins, prog[16]);
        end
        tick();
        @(negedge clk);
        total++;
        if (if_pc !== 32'h44) begin
            bad++;
            $display("FAIL redir_second: got pc=%h, want 44", if_pc);
        end
    endtask

    task automatic test_misaligned();
        tick(); redirect_valid = 1'b1; redirect_pc = 32'h42;
        exp_q.delete(); expect_stream(32'h40, 16);
        @(negedge clk);
        total++;
        if ({fetch_err, mem_en} !== 2'b10) begin
            bad++;
            $display("FAIL misalign_err: got err=%b en=%b, want 1 0", fetch_err, mem_en);
        end
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({fetch_err, mem_en, mem_addr, if_valid} !== {2'b01, 8'h10, 1'b0}) begin
            bad++;
            $display("FAIL misalign_resume: got err=%b en=%b addr=%h valid=%b, want 0 1 10 0",
                     fetch_err, mem_en, mem_addr, if_valid);
        end
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        total++;
        if ({if_valid, if_pc} !== {1'b1, 32'h40}) begin
            bad++;
            $display("FAIL misalign_first: got valid=%b pc=%h, want 1 40", if_valid, if_pc);
        end
    endtask

    task automatic test_mode_switch();
        tick(); boot_en = 1'b1; ld_valid = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEAD_BEEF;
        exp_q.delete();
        @(negedge clk);
        total++;
        if ({ld_ready, mem_we} !== 2'b00) begin
            bad++;
            $display("FAIL run_ld_ignored: got rdy=%b we=%b, want 0 0", ld_ready, mem_we);
        end
        tick();
        @(negedge clk);
        total++;
        if ({ld_ready, mem_en, mem_we, mem_addr, mem_wdata, if_valid} !==
            {3'b111, 8'd5, 32'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL reboot_write: got rdy=%b en=%b we=%b addr=%h wdata=%h valid=%b, want 1 1 1 05 deadbeef 0",
                     ld_ready, mem_en, mem_we, mem_addr, mem_wdata, if_valid);
        end
        prog[5] = 32'hDEAD_BEEF;
        tick(); ld_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({if_valid, mem_en} !== 2'b00) begin
            bad++;
            $display("FAIL reboot_quiet: got valid=%b en=%b, want 0 0", if_valid, mem_en);
        end
    endtask

    task automatic test_reset_midrun();
        int pops0;
        tick(); boot_en = 1'b0;
        expect_stream(32'h0, 8);
        pops0 = sb_pops;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            tick();
            @(negedge clk);
        end
        #1;
        total++;
        if ((sb_pops - pops0 !== 7) || (exp_q.size() !== 1)) begin
            bad++;
            $display("FAIL rerun_count: got %0d transfers, %0d left, want 7 and 1",
                     sb_pops - pops0, exp_q.size());
        end
        tick(); exp_q.delete(); rst_n = 1'b0;
        #1;
        total++;
        if ({ld_ready, mem_en, mem_we, mem_addr, mem_wdata, if_valid, if_pc, if_ins, fetch_err} !== '0) begin
            bad++;
            $display("FAIL reset_async: got rdy=%b en=%b valid=%b pc=%h ins=%h err=%b, want all 0",
                     ld_ready, mem_en, if_valid, if_pc, if_ins, fetch_err);
        end
        boot_en = 1'b1;
        @(negedge clk);
        total++;
        if ({ld_ready, mem_en} !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: got rdy=%b en=%b, want 0 0", ld_ready, mem_en);
        end
        tick(); rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ld_ready, if_valid, mem_en} !== 3'b100) begin
            bad++;
            $display("FAIL reset_boot: got rdy=%b valid=%b en=%b, want 1 0 0", ld_ready, if_valid, mem_en);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tmem[i] = '0;
            prog[i] = '0;
        end
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h0010_0113;
        for (int i = 2; i < 32; i++) begin
            prog[i] = 32'h0000_0013 + (32'(i) << 20) + (32'(i) << 7);
        end

        test_reset();
        test_boot_load();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_misaligned();
        test_mode_switch();
        test_reset_midrun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
